// File: rtl/eof_intermission.sv
// eof_intermission: CAN frame-tail sequencer driving recessive EOF, intermission and suspend fields.
// Define EOF_SUSPEND_EN to build the suspend-transmission field for error-passive transmitters.
module eof_intermission #(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3,
  parameter int SUSPEND_BITS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_point,
  input  logic             start_eof,
  input  logic             start_ifs,
  input  logic             is_transmitter,
  input  logic             error_passive,
  input  logic             rx_bit,
  output logic             tail_bit,
  output logic [1:0]       field,
  output logic [CNT_W-1:0] bit_counter,
  output logic             eof_complete,
  output logic             ifs_complete,
  output logic             form_error,
  output logic             overload_request,
  output logic             sof_detected,
  output logic             bus_idle
);
  localparam logic [1:0] IDLE = 2'd0, EOF = 2'd1, IFS = 2'd2, SUSP = 2'd3;
  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
  localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_BITS - 1);
  localparam logic [CNT_W-1:0] SUSP_LAST = CNT_W'(SUSPEND_BITS - 1);
  logic [1:0] field_q, field_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] pulse_q, pulse_d;
  logic idle_q, last, dom, susp_go;
`ifdef EOF_SUSPEND_EN
  assign susp_go = is_transmitter && error_passive;
`else
  logic unused_error_passive;
  assign unused_error_passive = error_passive;
  assign susp_go = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      field_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= '0;
      idle_q <= 1'b1;
    end else begin
      field_q <= field_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
      idle_q <= field_d == IDLE;
    end
  end
  assign last = cnt_q == (field_q == EOF ? EOF_LAST : field_q == IFS ? IFS_LAST : SUSP_LAST);
  assign dom = !rx_bit;
  // pulse vector: {eof_complete, ifs_complete, form_error, overload_request, sof_detected}
  always_comb begin
    field_d = field_q;
    cnt_d = cnt_q;
    pulse_d = '0;
    if (field_q == IDLE) begin
      field_d = start_eof ? EOF : start_ifs ? IFS : IDLE;
      cnt_d = '0;
    end else if (sample_point) begin
      cnt_d = (last || dom) ? '0 : cnt_q + 1'b1;
      case (field_q)
        EOF: begin
          field_d = dom ? IDLE : last ? IFS : EOF;
          pulse_d = {last && !dom, 1'b0, dom && (!last || is_transmitter), dom && last && !is_transmitter, 1'b0};
        end
        IFS: begin
          field_d = dom ? IDLE : !last ? IFS : susp_go ? SUSP : IDLE;
          pulse_d = {1'b0, last && !dom, 1'b0, dom && !last, dom && last};
        end
        default: begin
          field_d = (dom || last) ? IDLE : SUSP;
          pulse_d = {4'b0, dom};
        end
      endcase
    end
  end
  assign tail_bit = 1'b1;
  assign field = field_q;
  assign bit_counter = cnt_q;
  assign {eof_complete, ifs_complete, form_error, overload_request, sof_detected} = pulse_q;
  assign bus_idle = idle_q;
endmodule

// File: tb/tb_eof_intermission.sv
// tb_eof_intermission: randomized frame-tail sequences checked against a bit-stream outcome model.
module tb_eof_intermission;
  localparam int EB = 7, IB = 3, SB = 8, CW = 4;
`ifdef EOF_SUSPEND_EN
  localparam bit SUSP_EN = 1'b1;
`else
  localparam bit SUSP_EN = 1'b0;
`endif
  localparam logic [4:0] EOFC = 5'b10000, IFSC = 5'b01000, FORM = 5'b00100, OVL = 5'b00010, SOF = 5'b00001;
  logic clock = 0, reset = 1, enable = 1, sample_point = 0, start_eof = 0, start_ifs = 0;
  logic is_transmitter = 0, error_passive = 0, rx_bit = 1;
  logic tail_bit, eof_complete, ifs_complete, form_error, overload_request, sof_detected, bus_idle;
  logic [1:0] field;
  logic [CW-1:0] bit_counter;
  int n = 0, fails = 0;

  eof_intermission #(.EOF_BITS(EB), .IFS_BITS(IB), .SUSPEND_BITS(SB), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sample_point(sample_point),
    .start_eof(start_eof), .start_ifs(start_ifs), .is_transmitter(is_transmitter),
    .error_passive(error_passive), .rx_bit(rx_bit), .tail_bit(tail_bit), .field(field),
    .bit_counter(bit_counter), .eof_complete(eof_complete), .ifs_complete(ifs_complete),
    .form_error(form_error), .overload_request(overload_request), .sof_detected(sof_detected),
    .bus_idle(bus_idle)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check(input string tag, input int f, input int c, input logic [4:0] p);
    cmp({tag, ".field"}, 32'(field), f);
    cmp({tag, ".bit_counter"}, 32'(bit_counter), c);
    cmp({tag, ".pulses"}, 32'({eof_complete, ifs_complete, form_error, overload_request, sof_detected}), 32'(p));
    cmp({tag, ".bus_idle"}, 32'(bus_idle), 32'(f == 0));
    cmp({tag, ".tail_bit"}, 32'(tail_bit), 1);
  endtask

  task automatic tick(input logic sp, input logic rx, input logic se, input logic si);
    sample_point = sp;
    rx_bit = rx;
    start_eof = se;
    start_ifs = si;
    @(posedge clock);
    #1;
    sample_point = 0;
    start_eof = 0;
    start_ifs = 0;
  endtask

  // kind 1 = start_eof, 2 = start_ifs; d = absolute stream position of first dominant bit (-1 none)
  task automatic frame(input int kind, input bit tx, input bit ep, input int d, input string tag);
    int e1, e2, e3, t, a0, f, c;
    bit susp;
    logic [4:0] p;
    e1 = EB;
    e2 = EB + IB;
    susp = SUSP_EN && tx && ep;
    e3 = susp ? e2 + SB : e2;
    t = (d >= 0 && d < e3 - 1) ? d : e3 - 1;
    a0 = kind == 1 ? 0 : e1;
    is_transmitter = tx;
    error_passive = ep;
    tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), kind == 1,
         kind == 2 || (kind == 1 && $urandom_range(0, 1) == 1));
    check({tag, ".start"}, kind, 0, 5'b0);
    f = kind;
    c = 0;
    for (int a = a0; a <= t; a++) begin
      repeat ($urandom_range(0, 2)) begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check({tag, ".gap"}, f, c, 5'b0);
      end
      tick(1'b1, a != d, 1'b0, 1'b0);
      if (a == t) begin
        f = 0;
        c = 0;
        if (a == d) p = a < e1 - 1 ? FORM : a == e1 - 1 ? (tx ? FORM : OVL) : a < e2 - 1 ? OVL : SOF;
        else p = susp ? 5'b0 : IFSC;
      end else begin
        f = a + 1 < e1 ? 1 : a + 1 < e2 ? 2 : 3;
        c = a + 1 - (f == 1 ? 0 : f == 2 ? e1 : e2);
        p = a == e1 - 1 ? EOFC : a == e2 - 1 ? IFSC : 5'b0;
      end
      check(tag, f, c, p);
    end
  endtask

  initial begin
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    check("reset", 0, 0, 5'b0);
    reset = 0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_dominant", 0, 0, 5'b0);
    frame(1, 0, 0, -1, "eof_clean");
    frame(1, 0, 0, EB - 1, "eof_last_rx");
    frame(1, 1, 0, EB - 1, "eof_last_tx");
    frame(1, 0, 0, 3, "eof_idx3");
    frame(1, 0, 0, EB + 2, "ifs_idx2");
    frame(1, 1, 0, EB, "ifs_idx0");
    frame(2, 0, 0, -1, "ifs_direct");
    frame(1, 1, 1, -1, "suspend_clean");
    frame(1, 1, 1, EB + IB + 4, "suspend_idx4");
    for (int i = 0; i < 40; i++) begin
      int k, d;
      k = $urandom_range(1, 2);
      d = $urandom_range(0, 1) == 1 ? -1 : (k == 1 ? $urandom_range(0, EB + IB + SB - 1) : $urandom_range(EB, EB + IB + SB - 1));
      frame(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, "random");
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset", 1, 5, 5'b0);
    reset = 1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_abort", 0, 0, 5'b0);
    reset = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
    enable = 0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("disable_abort", 0, 0, 5'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("disabled_start", 0, 0, 5'b0);
    enable = 1;
    frame(1, 0, 0, -1, "after_enable");
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/eof_intermission.md
# eof_intermission

Parametrised frame-tail sequencer for the CAN data-frame path, successor to the fixed 7-bit EOF generator. After the ACK field, or after an error/overload delimiter, it drives recessive bits through End-Of-Frame, Intermission and (optionally) Suspend Transmission, counting bits on `sample_point`. It monitors the received bus level in every field and reports form errors, overload conditions and start-of-frame detection to the protocol controller.

## Interface
- `EOF_BITS`, default 7: length of the EOF field in bits (≥2).
- `IFS_BITS`, default 3: length of the intermission field in bits (≥2).
- `SUSPEND_BITS`, default 8: length of the suspend-transmission field in bits (≥1).
- `CNT_W`, default 4: bit-counter width; must hold `max(EOF_BITS, IFS_BITS, SUSPEND_BITS)`.

- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  low = synchronous return to reset values (same as `reset`).
- `sample_point`  in  1  one-cycle bit-time strobe from bit timing logic.
- `start_eof`  in  1  pulse: ACK field complete; begin EOF.
- `start_ifs`  in  1  pulse: error/overload delimiter complete; begin intermission directly.
- `is_transmitter`  in  1  node transmitted this frame.
- `error_passive`  in  1  node is error-passive.
- `rx_bit`  in  1  sampled bus level (0 = dominant), valid at `sample_point`.
- `tail_bit`  out  1  transmit level; always 1 (recessive).
- `field`  out  2  0 = IDLE, 1 = EOF, 2 = IFS, 3 = SUSPEND.
- `bit_counter`  out  CNT_W  bit index inside current field.
- `eof_complete`  out  1  one-cycle pulse, EOF finished without error.
- `ifs_complete`  out  1  one-cycle pulse, intermission finished.
- `form_error`  out  1  one-cycle pulse, dominant bit where recessive required.
- `overload_request`  out  1  one-cycle pulse, overload condition detected.
- `sof_detected`  out  1  one-cycle pulse, dominant bit taken as start of frame.
- `bus_idle`  out  1  high in IDLE.

## Operation
- All outputs registered. Reset/`!enable` values: `field`=0, `bit_counter`=0, all pulses 0, `tail_bit`=1, `bus_idle`=1.
- IDLE: `start_eof` → EOF; else `start_ifs` → IFS (`start_eof` wins if both). Counter cleared on entry to every field. `sample_point` in the same cycle as a start is not counted.
- Starts are ignored outside IDLE.
- Each `sample_point` in a field evaluates `rx_bit` at index `bit_counter`, then increments; at index N-1 the field ends.
- EOF: dominant at index < `EOF_BITS`-1 → `form_error`, go IDLE. Dominant at last index: receiver (`is_transmitter`=0) → `overload_request`, go IDLE; transmitter → `form_error`, go IDLE. Recessive at last index → `eof_complete`, go IFS.
- IFS: dominant at index < `IFS_BITS`-1 → `overload_request`, go IDLE. Dominant at last index → `sof_detected`, go IDLE. Recessive at last index → `ifs_complete`; go SUSPEND if `is_transmitter && error_passive` (sampled that cycle, macro enabled), else IDLE.
- SUSPEND: dominant at any index → `sof_detected`, go IDLE. Index `SUSPEND_BITS`-1 recessive → IDLE.
- Only one status pulse is ever asserted per cycle.
- Counter never wraps: fields end at N-1, so `bit_counter` ≤ N-1.

## Timing
- Start pulse at edge k → `field` updated after edge k (visible cycle k+1); `bus_idle` low same cycle.
- Terminating `sample_point` sampled at edge k → new `field`, cleared counter and one-cycle status pulse all visible after edge k; pulses deassert after edge k+1.
- Back-to-back: `start_eof` may be asserted the cycle after IDLE is re-entered and is accepted.
- `reset` or `!enable` mid-field: aborts at the next edge, no pulse emitted.
- `rx_bit` ignored when `sample_point` low.

## Configuration
- `EOF_SUSPEND_EN` defined: SUSPEND state built; error-passive transmitters wait `SUSPEND_BITS` after intermission.
- Undefined: no SUSPEND state, `error_passive` ignored, IFS completion always → IDLE; `field` never 3; `SUSPEND_BITS` unused.

## Test plan
- Defaults, `start_eof`, 10 recessive sample points → `eof_complete` after 7th, `ifs_complete` after 10th, `field` 1→2→0, `bus_idle` restored.
- Receiver, dominant at EOF index 6 → `overload_request` once, `field`=0, no `eof_complete`; transmitter same stimulus → `form_error`.
- Dominant at EOF index 3 → `form_error`; dominant at IFS index 2 → `sof_detected`; at IFS index 0 → `overload_request`.
- `EOF_SUSPEND_EN`, transmitter, `error_passive`=1: 7+3+8 recessive bits → `field`=3 for 8 bits then 0; dominant at suspend index 4 → `sof_detected`.
- `start_ifs` in IDLE → directly `field`=2, no `eof_complete`; `start_eof` mid-IFS ignored.
- `EOF_BITS`=11, `CNT_W`=4; reset asserted at EOF index 5 → all outputs at reset values next cycle, no pulses.
